// File: rtl/axi_lite_user_pkg.sv
// Shared definitions for the AXI-Lite user-side register bank:
// FSM state encoding, the out-of-range read pattern and address decoding.
package axi_lite_user_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_PUSH = 2'd2
    } state_t;

    // Pattern returned when a read targets an address past the register bank.
    localparam logic [31:0] BAD_READ_VALUE_DEFAULT = 32'hDEAD_BEEF;

    // Byte address to 32-bit-word index; the caller truncates to its index width.
    function automatic logic [31:0] byte_addr_to_index(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/axi_lite_user_regfile.sv
// Register bank served from the user side of the AXI-Lite FIFO slave bridge.
// Commands arrive as one-cycle enable pulses; write data is pulled from the
// bridge's write FIFO and read data is pushed into its read FIFO.
module axi_lite_user_regfile
    import axi_lite_user_pkg::*;
#(
    parameter int                    USER_ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    NUM_REGS        = 16,
    parameter int                    REG_INDEX_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] BAD_READ_VALUE  = DATA_WIDTH'(BAD_READ_VALUE_DEFAULT)
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [USER_ADDR_WIDTH-1:0]     user_addr,
    input  logic                           user_read_enable,
    input  logic                           user_write_enable,
    output logic                           user_ready,
    output logic                           user_write_deq,
    input  logic [DATA_WIDTH-1:0]          user_write_data,
    input  logic                           user_write_empty,
    output logic                           user_read_enq,
    output logic [DATA_WIDTH-1:0]          user_read_data,
    input  logic                           user_read_almost_full,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse,
    output logic                           error
);

    state_t                      state_reg;
    state_t                      state_next;
    logic [REG_INDEX_WIDTH-1:0]  index_reg;
    logic                        in_range_reg;
    logic                        user_read_enq_reg;
    logic [DATA_WIDTH-1:0]       user_read_data_reg;
    logic                        error_reg;

    logic [REG_INDEX_WIDTH-1:0]  cmd_index;
    logic                        cmd_in_range;
    logic                        cmd_accept;
    logic                        write_fire;
    logic                        read_fire;
    logic [DATA_WIDTH-1:0]       rd_word;

    // Decode the command address: word index plus "nothing above the bank" check.
    assign cmd_index    = REG_INDEX_WIDTH'(byte_addr_to_index(32'(user_addr)));
    assign cmd_in_range = ((user_addr >> (REG_INDEX_WIDTH + 2)) == '0);
    assign cmd_accept   = (state_reg == IDLE) && (user_read_enable || user_write_enable);

    // A write lands only in the dequeue cycle and only for an in-range index.
    assign write_fire = user_write_deq && in_range_reg;
    assign read_fire  = (state_reg == RD_PUSH) && !user_read_almost_full;

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic plus the state-derived handshake outputs.
    always_comb begin
        state_next     = state_reg;
        user_ready     = 1'b0;
        user_write_deq = 1'b0;
        case (state_reg)
            IDLE: begin
                if (user_read_enable) begin
                    state_next = RD_PUSH;
                end else if (user_write_enable) begin
                    state_next = WR_WAIT;
                end
            end
            WR_WAIT: begin
                user_ready = 1'b1;
                if (!user_write_empty) begin
                    user_write_deq = 1'b1;
                    state_next     = IDLE;
                end
            end
            RD_PUSH: begin
                user_ready = 1'b1;
                if (!user_read_almost_full) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the target index and range flag when a command is accepted.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            index_reg    <= '0;
            in_range_reg <= 1'b0;
        end else if (cmd_accept) begin
            index_reg    <= cmd_index;
            in_range_reg <= cmd_in_range;
        end
    end

    // One flop bank per register, each with its own update pulse.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] value_reg;
            logic                  pulse_reg;
            logic                  hit;

            assign hit = write_fire && (index_reg == REG_INDEX_WIDTH'(gi));

            // Load the FIFO head word and flag the update for one cycle.
            always_ff @(posedge ACLK) begin
                if (ARESET) begin
                    value_reg <= '0;
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= hit;
                    if (hit) begin
                        value_reg <= user_write_data;
                    end
                end
            end

            assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = value_reg;
            assign reg_wr_pulse[gi]                  = pulse_reg;
        end
    endgenerate

    // Select the register addressed by the latched index for a read.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (index_reg == REG_INDEX_WIDTH'(i)) begin
                rd_word = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Push read data into the read FIFO once it has room; strobe lasts one cycle.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            user_read_enq_reg  <= 1'b0;
            user_read_data_reg <= '0;
        end else begin
            user_read_enq_reg <= read_fire;
            if (read_fire) begin
                user_read_data_reg <= in_range_reg ? rd_word : BAD_READ_VALUE;
            end
        end
    end

    // Sticky error: colliding enables, enables while busy, out-of-range writes.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            error_reg <= 1'b0;
        end else if (((state_reg == IDLE) && user_read_enable && user_write_enable) ||
                     ((state_reg != IDLE) && (user_read_enable || user_write_enable)) ||
                     (user_write_deq && !in_range_reg)) begin
            error_reg <= 1'b1;
        end
    end

    assign user_read_enq  = user_read_enq_reg;
    assign user_read_data = user_read_data_reg;
    assign error          = error_reg;

endmodule

// File: tb/tb_axi_lite_user_regfile.sv
// Directed testbench for the AXI-Lite user-side register bank.
module tb_axi_lite_user_regfile;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic [7:0]   user_addr = '0;
    logic         user_read_enable = 1'b0;
    logic         user_write_enable = 1'b0;
    logic         user_ready;
    logic         user_write_deq;
    logic [31:0]  user_write_data = '0;
    logic         user_write_empty = 1'b1;
    logic         user_read_enq;
    logic [31:0]  user_read_data;
    logic         user_read_almost_full = 1'b0;
    logic [511:0] reg_q;
    logic [15:0]  reg_wr_pulse;
    logic         error;

    int total = 0;
    int bad   = 0;

    // Monitor state, sampled at the rising edge (values of the cycle just ending).
    int          cyc = 0;
    int          deq_cnt = 0;
    int          enq_cnt = 0;
    int          enq_cyc = 0;
    int          rd_en_cyc = 0;
    logic [31:0] enq_data = '0;

    logic [31:0] model [16];

    axi_lite_user_regfile dut (
        .ACLK                 (ACLK),
        .ARESET               (ARESET),
        .user_addr            (user_addr),
        .user_read_enable     (user_read_enable),
        .user_write_enable    (user_write_enable),
        .user_ready           (user_ready),
        .user_write_deq       (user_write_deq),
        .user_write_data      (user_write_data),
        .user_write_empty     (user_write_empty),
        .user_read_enq        (user_read_enq),
        .user_read_data       (user_read_data),
        .user_read_almost_full(user_read_almost_full),
        .reg_q                (reg_q),
        .reg_wr_pulse         (reg_wr_pulse),
        .error                (error)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (user_write_deq) deq_cnt <= deq_cnt + 1;
        if (user_read_enable) rd_en_cyc <= cyc;
        if (user_read_enq) begin
            enq_cnt  <= enq_cnt + 1;
            enq_cyc  <= cyc;
            enq_data <= user_read_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        repeat (3) tick();
        ARESET = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        $display("txn reset");
    endtask

    // One-cycle command pulse; returns #1 after the edge that sampled it.
    task automatic cmd(input logic rd, input logic wr, input logic [7:0] a);
        user_addr         = a;
        user_read_enable  = rd;
        user_write_enable = wr;
        tick();
        user_read_enable  = 1'b0;
        user_write_enable = 1'b0;
        $display("txn cmd rd=%0b wr=%0b addr=%02h", rd, wr, a);
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 16; i++) chk(tag, reg_q[i*32 +: 32], model[i]);
    endtask

    int deq0, enq0, drop_cyc;

    initial begin
        // Reset state
        do_reset();
        @(negedge ACLK);
        chk("rst_ready", user_ready, 0);
        chk("rst_error", error, 0);
        chk("rst_deq", user_write_deq, 0);
        chk("rst_enq", user_read_enq, 0);
        chk("rst_rdata", user_read_data, 0);
        chk("rst_pulse", reg_wr_pulse, 0);
        chk_regs("rst_regq");

        // Write 0x08 with the FIFO word arriving 5 cycles late
        deq0 = deq_cnt;
        cmd(0, 1, 8'h08);
        chk("wr_ready_hi", user_ready, 1);
        repeat (5) tick();
        chk("wr_wait_nodeq", deq_cnt - deq0, 0);
        chk("wr_wait_ready", user_ready, 1);
        user_write_data  = 32'h1234_5678;
        user_write_empty = 1'b0;
        @(negedge ACLK);
        chk("wr_deq_strobe", user_write_deq, 1);
        tick();
        user_write_empty = 1'b1;
        model[2] = 32'h1234_5678;
        @(negedge ACLK);
        chk("wr_pulse", reg_wr_pulse, 16'h0004);
        chk("wr_ready_lo", user_ready, 0);
        chk_regs("wr_regq");
        tick();
        @(negedge ACLK);
        chk("wr_pulse_gone", reg_wr_pulse, 0);
        chk("wr_deq_once", deq_cnt - deq0, 1);
        chk("wr_err", error, 0);

        // Read 0x08 with FIFO space: enq two cycles after the enable
        enq0 = enq_cnt;
        cmd(1, 0, 8'h08);
        repeat (3) tick();
        chk("rd_enq_once", enq_cnt - enq0, 1);
        chk("rd_latency", enq_cyc - rd_en_cyc, 2);
        chk("rd_data", enq_data, 32'h1234_5678);
        chk("rd_ready_lo", user_ready, 0);

        // Read 0x08 while almost-full is held for 10 cycles
        enq0 = enq_cnt;
        user_read_almost_full = 1'b1;
        cmd(1, 0, 8'h08);
        repeat (10) tick();
        chk("af_no_enq", enq_cnt - enq0, 0);
        chk("af_ready", user_ready, 1);
        user_read_almost_full = 1'b0;
        drop_cyc = cyc;
        repeat (3) tick();
        chk("af_enq_once", enq_cnt - enq0, 1);
        chk("af_enq_cycle", enq_cyc - drop_cyc, 1);
        chk("af_data", enq_data, 32'h1234_5678);

        // Out-of-range write 0x80
        deq0 = deq_cnt;
        cmd(0, 1, 8'h80);
        user_write_data  = 32'hCAFE_F00D;
        user_write_empty = 1'b0;
        tick();
        user_write_empty = 1'b1;
        @(negedge ACLK);
        chk("oor_pulse", reg_wr_pulse, 0);
        chk("oor_deq_once", deq_cnt - deq0, 1);
        chk("oor_err", error, 1);
        chk_regs("oor_regq");

        // Out-of-range read 0x80
        enq0 = enq_cnt;
        tick();
        cmd(1, 0, 8'h80);
        repeat (3) tick();
        chk("oor_rd_enq", enq_cnt - enq0, 1);
        chk("oor_rd_data", enq_data, 32'hDEAD_BEEF);

        // Both enables together at 0x04: read wins
        do_reset();
        @(negedge ACLK);
        chk("rst2_err", error, 0);
        chk_regs("rst2_regq");
        cmd(0, 1, 8'h04);
        user_write_data  = 32'hA5A5_0001;
        user_write_empty = 1'b0;
        tick();
        user_write_empty = 1'b1;
        model[1] = 32'hA5A5_0001;
        @(negedge ACLK);
        chk("w1_pulse", reg_wr_pulse, 16'h0002);
        chk("w1_err", error, 0);
        tick();
        deq0 = deq_cnt;
        enq0 = enq_cnt;
        user_write_data  = 32'h0000_0099;
        user_write_empty = 1'b0;
        cmd(1, 1, 8'h04);
        repeat (3) tick();
        chk("both_nodeq", deq_cnt - deq0, 0);
        chk("both_enq", enq_cnt - enq0, 1);
        chk("both_data", enq_data, 32'hA5A5_0001);
        chk("both_err", error, 1);
        user_write_empty = 1'b1;

        // Enable pulsed during WR_WAIT is dropped
        do_reset();
        deq0 = deq_cnt;
        enq0 = enq_cnt;
        cmd(0, 1, 8'h0C);
        tick();
        cmd(1, 0, 8'h08);
        tick();
        @(negedge ACLK);
        chk("busy_err", error, 1);
        chk("busy_ready", user_ready, 1);
        user_write_data  = 32'h0BAD_F00D;
        user_write_empty = 1'b0;
        tick();
        user_write_empty = 1'b1;
        model[3] = 32'h0BAD_F00D;
        @(negedge ACLK);
        chk("busy_pulse", reg_wr_pulse, 16'h0008);
        chk_regs("busy_regq");
        repeat (3) tick();
        chk("busy_deq", deq_cnt - deq0, 1);
        chk("busy_no_enq", enq_cnt - enq0, 0);
        chk("busy_idle", user_ready, 0);

        // Reset while waiting for write data abandons the write
        do_reset();
        deq0 = deq_cnt;
        cmd(0, 1, 8'h10);
        chk("rw_ready_hi", user_ready, 1);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("rw_ready_lo", user_ready, 0);
        user_write_data  = 32'h7777_7777;
        user_write_empty = 1'b0;
        repeat (5) tick();
        chk("rw_no_deq", deq_cnt - deq0, 0);
        chk("rw_no_pulse", reg_wr_pulse, 0);
        chk_regs("rw_regq");
        user_write_empty = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_user_regfile.md
Name: axi_lite_user_regfile

Overview:
- Register-bank server on the user side of the AXI-Lite FIFO slave bridge.
- Consumes the bridge's command channel (user_addr, read/write enable pulses) and its write-data FIFO.
- Returns read data by enqueuing into the bridge's read-data FIFO.
- Exposes the register contents and per-register write pulses to user logic.

Parameters:
- USER_ADDR_WIDTH, 8, width of user_addr (byte address from the bridge).
- DATA_WIDTH, 32, register and data-FIFO word width.
- NUM_REGS, 16, number of registers; a power of two, at most 2**(USER_ADDR_WIDTH-2).
- REG_INDEX_WIDTH, 4, log2(NUM_REGS).
- BAD_READ_VALUE, 32'hDEAD_BEEF, data returned for an out-of-range read.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- user_addr  in  USER_ADDR_WIDTH  byte address; valid in the cycle an enable is high.
- user_read_enable  in  1  one-cycle read command pulse.
- user_write_enable  in  1  one-cycle write command pulse.
- user_ready  out  1  busy/ack to the bridge; high while a command is in progress.
- user_write_deq  out  1  dequeue strobe to the write-data FIFO.
- user_write_data  in  DATA_WIDTH  write FIFO head word; valid whenever user_write_empty is low.
- user_write_empty  in  1  write FIFO empty.
- user_read_enq  out  1  enqueue strobe to the read-data FIFO.
- user_read_data  out  DATA_WIDTH  read data to enqueue.
- user_read_almost_full  in  1  read FIFO almost full.
- reg_q  out  NUM_REGS*DATA_WIDTH  flat register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- reg_wr_pulse  out  NUM_REGS  one-hot, one-cycle pulse on each register update.
- error  out  1  sticky protocol/address error flag.

Behaviour:
- Reset (ARESET=1 at a clock edge):
  - State goes to IDLE.
  - All registers and reg_q are 0; reg_wr_pulse=0.
  - user_read_enq=0, user_read_data=0, error=0.
  - user_ready and user_write_deq are 0, because both derive from state.
  - Reset mid-command abandons the command; no FIFO strobe is issued afterwards.
- Register index: user_addr[REG_INDEX_WIDTH+1:2]. Bits [1:0] are ignored. The address is in range iff user_addr[USER_ADDR_WIDTH-1:REG_INDEX_WIDTH+2]==0.
- States: IDLE, WR_WAIT, RD_PUSH.
- IDLE:
  - On user_read_enable: latch index and range flag; next state RD_PUSH.
  - Else on user_write_enable: latch index and range flag; next state WR_WAIT.
  - Both enables high in the same cycle: read wins and error is set.
- user_ready = (state != IDLE), combinational from the state register. It rises the cycle after the enable pulse.
- WR_WAIT:
  - user_write_deq = (state==WR_WAIT && !user_write_empty), combinational.
  - In the deq cycle, user_write_data is written to the latched register if in range; reg_wr_pulse[index]=1 for the following cycle only.
  - Out of range: the FIFO word is still dequeued and discarded, no register changes, error is set.
  - Next state IDLE. The FIFO is dequeued exactly once per write command.
  - If the FIFO stays empty, the block stays in WR_WAIT indefinitely (no timeout).
- RD_PUSH:
  - When user_read_almost_full=0: register user_read_enq=1 and user_read_data=register value (or BAD_READ_VALUE if out of range); next state IDLE.
  - user_read_enq is a one-cycle pulse.
  - While almost_full is high: wait, no enqueue.
  - Read latency with FIFO space: the enq pulse occurs 2 cycles after the enable pulse.
- Enable pulse while state != IDLE: the command is dropped, error is set, and the current command continues unaffected.
- Write followed by read of the same register returns the new value, because the write lands before IDLE is re-entered.
- error clears only on reset.

Decomposition:
- Shared package axi_lite_user_pkg holds:
  - state encoding (IDLE=2'd0, WR_WAIT=2'd1, RD_PUSH=2'd2);
  - the BAD_READ_VALUE default;
  - a function converting byte address to register index.
- No sub-module; the register array and the FSM are in a single module.

Test Plan:
- Reset with ARESET=1 for 3 cycles → reg_q all 0, user_ready=0, error=0, no strobes.
- Write cmd addr=0x08, then FIFO word 0x12345678 arriving 5 cycles later → deq pulses once when empty drops, reg 2=0x12345678, reg_wr_pulse=0x0004 for one cycle, user_ready back to 0.
- Read cmd addr=0x08 with almost_full=0 → user_read_enq single pulse 2 cycles after the enable, user_read_data=0x12345678. Repeat with almost_full held high 10 cycles → enq occurs only the cycle after it drops.
- Write addr=0x80 (out of range, defaults) with data 0xCAFEF00D → one deq, no reg change, error=1. Read addr=0x80 → data 0xDEADBEEF.
- Read and write enables asserted together at addr=0x04 → read performed, no deq, error=1. Enable pulsed during WR_WAIT → ignored, error=1, pending write completes normally.
- ARESET asserted while in WR_WAIT with FIFO empty → IDLE next cycle. FIFO word arriving afterwards is never dequeued.
